seg_display_sched: RTL and testbench

//  Round-robin scheduler that shares the 4-digit seven-segment display between two requesters,

---
 rtl/seg_display_sched.sv | 90 +++++++++
 tb/tb_seg_display_sched.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_sched.sv
// Round-robin scheduler sharing one 4-digit seven-segment display between two
// frame requesters; each accepted frame is held for DWELL_CYCLES before the next grant.
module seg_display_sched #(
  parameter int unsigned DWELL_CYCLES = 25_000_000,
  parameter int unsigned DWELL_W      = 25
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic [27:0] req0_frame,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [27:0] req1_frame,
  output logic        req1_ready,
  output logic [6:0]  digit0,
  output logic [6:0]  digit1,
  output logic [6:0]  digit2,
  output logic [6:0]  digit3,
  output logic        owner,
  output logic        busy
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [DWELL_W-1:0] RELOAD = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [6:0]         BLANK  = 7'h7F;

  state_t             state, state_nxt;
  logic               last_grant;
  logic               grant;
  logic               grant_vld;
  logic               accept;
  logic [DWELL_W-1:0] cnt;
  logic [27:0]        frame_sel;

  // Contention goes to the requester that did not win last time; a lone
  // requester is granted even if it won last time.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    grant     = 1'b0;
    grant_vld = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  // Readies are gated by reset so nothing looks accepted while reset is held.
  assign req0_ready = reset_n && (state == IDLE) && grant_vld && !grant;
  assign req1_ready = reset_n && (state == IDLE) && grant_vld &&  grant;
  assign accept     = req0_ready | req1_ready;
  assign frame_sel  = grant ? req1_frame : req0_frame;
  assign busy       = (state == HOLD);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = HOLD;
      HOLD:    if (cnt == '0) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      cnt        <= '0;
      owner      <= 1'b0;
      digit0     <= BLANK;
      digit1     <= BLANK;
      digit2     <= BLANK;
      digit3     <= BLANK;
    end else if (accept) begin
      last_grant <= grant;
      owner      <= grant;
      cnt        <= RELOAD;
      digit0     <= frame_sel[6:0];
      digit1     <= frame_sel[13:7];
      digit2     <= frame_sel[20:14];
      digit3     <= frame_sel[27:21];
    end else if (state == HOLD && cnt != '0) begin
      cnt <= cnt - DWELL_W'(1);
    end
  end

endmodule

// File: tb/tb_seg_display_sched.sv
// Scoreboard bench for seg_display_sched (DWELL_CYCLES=4): stimulus pushes the
// expected accepted frames, a monitor compares display and owner after each transfer.
module tb_seg_display_sched;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic [27:0] req0_frame, req1_frame;
  logic        req0_ready, req1_ready;
  logic [6:0]  digit0, digit1, digit2, digit3;
  logic        owner, busy;

  seg_display_sched #(.DWELL_CYCLES(4), .DWELL_W(3)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_frame (req0_frame),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_frame (req1_frame),
    .req1_ready (req1_ready),
    .digit0     (digit0),
    .digit1     (digit1),
    .digit2     (digit2),
    .digit3     (digit3),
    .owner      (owner),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       own;
    logic [6:0] d0, d1, d2, d3;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [27:0] mk(input logic [6:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic push(input logic own, input logic [6:0] d3, d2, d1, d0);
    exp_t e;
    e.own = own; e.d0 = d0; e.d1 = d1; e.d2 = d2; e.d3 = d3;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (!busy) seen = 1'b1;
      else tick();
    end
    check("wait_idle_timeout", {31'b0, seen}, 32'd1);
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_digit0"}, {25'b0, digit0}, 32'h7F);
    check({tag, "_digit1"}, {25'b0, digit1}, 32'h7F);
    check({tag, "_digit2"}, {25'b0, digit2}, 32'h7F);
    check({tag, "_digit3"}, {25'b0, digit3}, 32'h7F);
    check({tag, "_owner"},  {31'b0, owner},  32'd0);
    check({tag, "_busy"},   {31'b0, busy},   32'd0);
    check({tag, "_ready0"}, {31'b0, req0_ready}, 32'd0);
    check({tag, "_ready1"}, {31'b0, req1_ready}, 32'd0);
  endtask

  // Monitor: a handshake seen mid-cycle is compared against the scoreboard
  // half a cycle after the accepting edge.
  initial begin
    bit   pending = 1'b0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (pending) begin
        pending = 1'b0;
        if (sb.size() == 0) begin
          check("unexpected_accept", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("acc_owner",  {31'b0, owner},  {31'b0, e.own});
          check("acc_digit0", {25'b0, digit0}, {25'b0, e.d0});
          check("acc_digit1", {25'b0, digit1}, {25'b0, e.d1});
          check("acc_digit2", {25'b0, digit2}, {25'b0, e.d2});
          check("acc_digit3", {25'b0, digit3}, {25'b0, e.d3});
        end
      end
      check("readies_exclusive", {31'b0, req0_ready & req1_ready}, 32'd0);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) pending = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    bit found;

    // Reset held with both requesters valid
    reset_n    = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_frame = mk(7'h11, 7'h22, 7'h33, 7'h44);
    req1_frame = mk(7'h55, 7'h66, 7'h77, 7'h0F);
    repeat (3) tick();
    check_blank("reset");

    // Contention after release: grants alternate starting with req0
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 7'h11, 7'h22, 7'h33, 7'h44);
      push(1'b1, 7'h55, 7'h66, 7'h77, 7'h0F);
    end
    reset_n = 1'b1;
    #1;
    check("first_ready0", {31'b0, req0_ready}, 32'd1);
    check("first_ready1", {31'b0, req1_ready}, 32'd0);
    repeat (28) tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();

    // Single request: 4 busy cycles, ready again 5 edges after accept
    req0_frame = mk(7'h40, 7'h79, 7'h24, 7'h30);
    req0_valid = 1'b1;
    #1;
    check("single_ready0", {31'b0, req0_ready}, 32'd1);
    push(1'b0, 7'h40, 7'h79, 7'h24, 7'h30);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("single_busy", {31'b0, busy}, 32'd1);
      check("hold_ready0", {31'b0, req0_ready}, 32'd0);
      tick();
    end
    check("single_busy_end", {31'b0, busy}, 32'd0);
    check("single_ready_again", {31'b0, req0_ready}, 32'd1);
    req0_valid = 1'b0;

    // Single-source repeat on req1
    req1_frame = mk(7'h19, 7'h12, 7'h02, 7'h78);
    req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) push(1'b1, 7'h19, 7'h12, 7'h02, 7'h78);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("repeat_owner", {31'b0, owner}, 32'd1);
    end
    req1_valid = 1'b0;
    wait_idle();

    // Late valid and frame changes during a req0 hold are ignored
    req0_frame = mk(7'h00, 7'h10, 7'h08, 7'h03);
    req0_valid = 1'b1;
    push(1'b0, 7'h00, 7'h10, 7'h08, 7'h03);
    push(1'b1, 7'h46, 7'h21, 7'h06, 7'h0E);
    tick();
    req1_frame = mk(7'h46, 7'h21, 7'h06, 7'h0E);
    req1_valid = 1'b1;
    req0_frame = mk(7'h7E, 7'h7D, 7'h7B, 7'h77);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("late_digit0", {25'b0, digit0}, 32'h03);
      check("late_digit3", {25'b0, digit3}, 32'h00);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (req1_ready) found = 1'b1;
      else tick();
    end
    check("late_req1_granted", {31'b0, found}, 32'd1);
    check("late_ready0_low", {31'b0, req0_ready}, 32'd0);
    check("late_digits_held", {25'b0, digit1}, 32'h08);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();

    // Reset pulsed mid-dwell
    req1_frame = mk(7'h3F, 7'h5F, 7'h6F, 7'h1F);
    req1_valid = 1'b1;
    push(1'b1, 7'h3F, 7'h5F, 7'h6F, 7'h1F);
    tick();
    req1_valid = 1'b0;
    tick();
    tick();
    check("mid_busy", {31'b0, busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_blank("mid_reset");
    req0_frame = mk(7'h2A, 7'h55, 7'h2B, 7'h54);
    req1_frame = mk(7'h0A, 7'h0B, 7'h0C, 7'h0D);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    tick();
    tick();
    push(1'b0, 7'h2A, 7'h55, 7'h2B, 7'h54);
    reset_n = 1'b1;
    #1;
    check("post_reset_ready0", {31'b0, req0_ready}, 32'd1);
    check("post_reset_ready1", {31'b0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();
    repeat (3) tick();
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
